jtpopeye_romload_ctrl: RTL and testbench

// - Sequences the MiSTer ioctl ROM download into the game's ROM stores.
// - Splits the linear download stream into main-CPU, character, object and PROM regions.
// - Issues one region-relative write strobe per ioctl byte.
// - Holds the game core in reset until the image is complete and settled.
// - Sits between hps_io and jtpopeye_game and is the sole owner of the game reset.

---
 rtl/jtpopeye_pkg.sv | 28 ++
 rtl/jtpopeye_romload_ctrl_if.sv | 24 ++
 rtl/jtpopeye_romload_dec.sv | 37 +++
 rtl/jtpopeye_romload_ctrl.sv | 115 +++++++++++
 tb/tb_jtpopeye_romload_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye ROM download path: region map,
// download sequencer states and the prog_we strobe layout.
package jtpopeye_pkg;

  // First address past each region; each region starts at the previous end
  localparam logic [21:0] MAIN_END = 22'h08000;
  localparam logic [21:0] CHR_END  = 22'h09000;
  localparam logic [21:0] OBJ_END  = 22'h11000;
  localparam logic [21:0] PROM_END = 22'h11340;

  // Default number of cycles the game stays in reset after the last byte
  localparam int HOLD_CYC_DEF = 16;

  // Bit positions inside the one-hot prog_we strobe
  localparam int WE_MAIN = 0;
  localparam int WE_CHR  = 1;
  localparam int WE_OBJ  = 2;
  localparam int WE_PROM = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } romload_st_t;

endpackage

// File: rtl/jtpopeye_romload_ctrl_if.sv
// ioctl download stream in, region write port out.
// master: the download source / ROM store side (hps_io + game memories).
// slave : the download sequencer.
interface jtpopeye_romload_ctrl_if;

  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [14:0] prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  prog_we;

  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr,
    input  prog_addr, prog_data, prog_we
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr,
    output prog_addr, prog_data, prog_we
  );

endinterface

// File: rtl/jtpopeye_romload_dec.sv
// Combinational region decoder: linear download address to one-hot region
// strobe and region-relative offset. Shared with the simulation preloader.
import jtpopeye_pkg::*;

module jtpopeye_romload_dec (
  input  logic [21:0] addr,
  output logic [3:0]  we,
  output logic [14:0] off,
  output logic        bad
);

  logic [21:0] rel;

  // Ordered unsigned compares pick the first region whose end lies above addr
  always_comb begin
    we  = '0;
    bad = 1'b0;
    rel = '0;
    if (addr < MAIN_END) begin
      we[WE_MAIN] = 1'b1;
      rel         = addr;
    end else if (addr < CHR_END) begin
      we[WE_CHR] = 1'b1;
      rel        = addr - MAIN_END;
    end else if (addr < OBJ_END) begin
      we[WE_OBJ] = 1'b1;
      rel        = addr - CHR_END;
    end else if (addr < PROM_END) begin
      we[WE_PROM] = 1'b1;
      rel         = addr - OBJ_END;
    end else begin
      bad = 1'b1;
    end
    off = rel[14:0];
  end

endmodule

// File: rtl/jtpopeye_romload_ctrl.sv
// ROM download sequencer: routes ioctl bytes into the ROM regions, owns the
// game reset and reports whether the loaded image was complete and in range.
import jtpopeye_pkg::*;

module jtpopeye_romload_ctrl #(
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  jtpopeye_romload_ctrl_if.slave  io,
  output logic                    game_rst,
  output logic                    load_done,
  output logic                    rom_short,
  output logic                    bad_addr
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  romload_st_t      st;
  logic [CNT_W-1:0] hold_cnt;
  logic [21:0]      max_addr;
  logic             seen;
  logic [3:0]       dec_we;
  logic [14:0]      dec_off;
  logic             dec_bad;
  logic             wr_ok;
  logic [22:0]      img_end;

  jtpopeye_romload_dec u_dec (
    .addr (io.ioctl_addr),
    .we   (dec_we),
    .off  (dec_off),
    .bad  (dec_bad)
  );

  // A strobe counts only while loading; the LOAD cycle in which downloading
  // drops is still LOAD, so the final byte is captured and drained by FLUSH.
  assign wr_ok   = (st == LOAD) && io.ioctl_wr;
  assign img_end = {1'b0, max_addr} + 23'd1;

  // The game is held unless running; a new download raises it before the
  // state register has even moved.
  assign game_rst = (st != RUN) || io.downloading;

  // Sequencer, hold counter, address tracker and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      hold_cnt  <= '0;
      max_addr  <= '0;
      seen      <= 1'b0;
      load_done <= 1'b0;
      rom_short <= 1'b0;
      bad_addr  <= 1'b0;
    end else begin
      if (wr_ok) begin
        seen <= 1'b1;
        if (!seen || io.ioctl_addr > max_addr) max_addr <= io.ioctl_addr;
        if (dec_bad) bad_addr <= 1'b1;
      end
      case (st)
        IDLE, RUN: begin
          if (io.downloading) begin
            st        <= LOAD;
            load_done <= 1'b0;
            rom_short <= 1'b0;
            bad_addr  <= 1'b0;
            seen      <= 1'b0;
            max_addr  <= '0;
          end
        end
        LOAD: begin
          if (!io.downloading) st <= FLUSH;
        end
        FLUSH: begin
          rom_short <= !seen || (img_end < {1'b0, PROM_END});
          hold_cnt  <= '0;
          st        <= HOLD;
        end
        HOLD: begin
          if (io.downloading) begin
            st        <= LOAD;
            load_done <= 1'b0;
            rom_short <= 1'b0;
            bad_addr  <= 1'b0;
            seen      <= 1'b0;
            max_addr  <= '0;
          end else if (hold_cnt == CNT_W'(HOLD_CYC - 1)) begin
            st        <= RUN;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Write port: one registered strobe per accepted byte, one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.prog_we   <= '0;
      io.prog_addr <= '0;
      io.prog_data <= '0;
    end else begin
      io.prog_we <= wr_ok ? dec_we : 4'd0;
      if (wr_ok) begin
        io.prog_addr <= dec_off;
        io.prog_data <= io.ioctl_data;
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_romload_ctrl.sv
// Directed bench for the ROM download sequencer.
`timescale 1ns/1ps
module tb_jtpopeye_romload_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_rst, load_done, rom_short, bad_addr;

  int checks = 0;
  int errors = 0;

  int n_main = 0, n_chr = 0, n_obj = 0, n_prom = 0, n_multi = 0, n_dbad = 0;
  bit mon_data = 1'b0;

  jtpopeye_romload_ctrl_if bus ();

  jtpopeye_romload_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus.slave),
    .game_rst  (game_rst),
    .load_done (load_done),
    .rom_short (rom_short),
    .bad_addr  (bad_addr)
  );

  always #5 clk = ~clk;

  // Strobe tally, sampled on the inactive edge
  always @(negedge clk) begin
    if (bus.prog_we[0]) n_main++;
    if (bus.prog_we[1]) n_chr++;
    if (bus.prog_we[2]) n_obj++;
    if (bus.prog_we[3]) n_prom++;
    if ($countones(bus.prog_we) > 1) n_multi++;
    if (mon_data && bus.prog_we != 4'd0 && bus.prog_data !== bus.prog_addr[7:0]) n_dbad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte strobe; checks the registered write one cycle later
  task automatic wr_byte(input string tag, input logic [21:0] a, input logic [7:0] d,
                         input logic [3:0] we, input logic [14:0] off);
    @(negedge clk);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
    @(posedge clk);
    #1;
    bus.ioctl_wr = 1'b0;
    chk({tag, "_we"}, 32'(bus.prog_we), 32'(we));
    if (we != 4'd0) begin
      chk({tag, "_addr"}, 32'(bus.prog_addr), 32'(off));
      chk({tag, "_data"}, 32'(bus.prog_data), 32'(d));
    end
  endtask

  task automatic start_dl();
    @(negedge clk);
    bus.downloading = 1'b1;
    @(negedge clk);
  endtask

  // Drop downloading and check the release: the edge after the drop moves
  // to FLUSH, one more edge to HOLD, then HOLD_CYC hold cycles.
  task automatic end_dl_release(input string tag);
    @(negedge clk);
    bus.downloading = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk({tag, "_rst_held"}, 32'(game_rst), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_rst_rel"}, 32'(game_rst), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd1);
  endtask

  initial begin
    int s_main, s_chr, s_obj, s_prom;
    bus.downloading = 1'b0;
    bus.ioctl_addr  = '0;
    bus.ioctl_data  = '0;
    bus.ioctl_wr    = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_game_rst", 32'(game_rst), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_rom_short", 32'(rom_short), 32'd0);
    chk("rst_bad_addr", 32'(bad_addr), 32'd0);
    chk("rst_prog_we", 32'(bus.prog_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write while idle is ignored
    wr_byte("idle_wr", 22'h00010, 8'h55, 4'd0, 15'd0);

    // Full image, back-to-back bytes, data = low address byte
    s_main = n_main; s_chr = n_chr; s_obj = n_obj; s_prom = n_prom;
    mon_data = 1'b1;
    start_dl();
    for (int a = 0; a < 32'h11340; a++) begin
      bus.ioctl_addr = 22'(a);
      bus.ioctl_data = a[7:0];
      bus.ioctl_wr   = 1'b1;
      @(negedge clk);
    end
    bus.ioctl_wr = 1'b0;
    end_dl_release("full");
    mon_data = 1'b0;
    chk("full_n_main", 32'(n_main - s_main), 32'h8000);
    chk("full_n_chr", 32'(n_chr - s_chr), 32'h1000);
    chk("full_n_obj", 32'(n_obj - s_obj), 32'h8000);
    chk("full_n_prom", 32'(n_prom - s_prom), 32'h340);
    chk("full_multi_hot", 32'(n_multi), 32'd0);
    chk("full_data", 32'(n_dbad), 32'd0);
    chk("full_rom_short", 32'(rom_short), 32'd0);
    chk("full_bad_addr", 32'(bad_addr), 32'd0);

    // Write in RUN without downloading: ignored, flags untouched
    wr_byte("run_wr", 22'h00020, 8'h66, 4'd0, 15'd0);
    chk("run_wr_done", 32'(load_done), 32'd1);

    // Downloading rising in RUN raises game_rst combinationally
    @(negedge clk);
    bus.downloading = 1'b1;
    #1;
    chk("run_dl_rise_rst", 32'(game_rst), 32'd1);
    @(posedge clk);
    #1;
    chk("load_clears_done", 32'(load_done), 32'd0);

    // Region boundaries
    wr_byte("b_7fff", 22'h07FFF, 8'h11, 4'b0001, 15'h7FFF);
    wr_byte("b_8000", 22'h08000, 8'h22, 4'b0010, 15'h0000);
    wr_byte("b_10fff", 22'h10FFF, 8'h33, 4'b0100, 15'h7FFF);
    wr_byte("b_11000", 22'h11000, 8'h44, 4'b1000, 15'h0000);
    wr_byte("b_1133f", 22'h1133F, 8'h45, 4'b1000, 15'h033F);

    // Eight consecutive strobes
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.ioctl_addr = 22'h00100 + 22'(i);
      bus.ioctl_data = 8'hA0 + 8'(i);
      bus.ioctl_wr   = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_we", 32'(bus.prog_we), 32'h1);
      chk("b2b_addr", 32'(bus.prog_addr), 32'h100 + 32'(i));
      chk("b2b_data", 32'(bus.prog_data), 32'hA0 + 32'(i));
    end
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_end_we", 32'(bus.prog_we), 32'd0);

    // Out of range
    chk("bad_before", 32'(bad_addr), 32'd0);
    wr_byte("oor_12000", 22'h12000, 8'h77, 4'd0, 15'd0);
    chk("bad_set", 32'(bad_addr), 32'd1);
    end_dl_release("oor");
    chk("oor_bad_sticky", 32'(bad_addr), 32'd1);

    // Short image: stops at 0x09000; bad_addr clears on new download
    start_dl();
    chk("bad_cleared", 32'(bad_addr), 32'd0);
    wr_byte("short_0", 22'h00000, 8'h01, 4'b0001, 15'h0000);
    wr_byte("short_8fff", 22'h08FFF, 8'h02, 4'b0010, 15'h0FFF);
    end_dl_release("short");
    chk("short_rom_short", 32'(rom_short), 32'd1);

    // Downloading pulse during HOLD: hold restarts, tracker was cleared
    start_dl();
    wr_byte("hold_1133f", 22'h1133F, 8'h09, 4'b1000, 15'h033F);
    @(negedge clk);
    bus.downloading = 1'b0;
    repeat (8) @(negedge clk);
    bus.downloading = 1'b1;
    #1;
    chk("hold_pulse_rst", 32'(game_rst), 32'd1);
    end_dl_release("hold");
    chk("hold_rom_short", 32'(rom_short), 32'd1);

    // Empty download
    start_dl();
    end_dl_release("empty");
    chk("empty_rom_short", 32'(rom_short), 32'd1);

    // Reset during LOAD aborts everything
    start_dl();
    wr_byte("abort_oor", 22'h12000, 8'h88, 4'd0, 15'd0);
    chk("abort_bad_pre", 32'(bad_addr), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_game_rst", 32'(game_rst), 32'd1);
    chk("abort_bad", 32'(bad_addr), 32'd0);
    chk("abort_done", 32'(load_done), 32'd0);
    chk("abort_short", 32'(rom_short), 32'd0);
    chk("abort_we", 32'(bus.prog_we), 32'd0);
    bus.downloading = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // Back in IDLE: strobes ignored, still held
    wr_byte("abort_idle_wr", 22'h00005, 8'h99, 4'd0, 15'd0);
    chk("abort_idle_rst", 32'(game_rst), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
